// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - button debounce, run/clear FSM and lap display hold for the stopwatch
//
// Purpose:
//   Synchronises and debounces the start/stop, lap and clear buttons, turns each
//   debounced rising edge into a one-cycle press pulse, and runs the
//   IDLE/RUNNING/PAUSED/LAP state machine that drives the BCD counter's count
//   enable and clear. In LAP the display digits are frozen while the counter
//   keeps running.
//
// Optional feature:
//   STOPWATCH_AUTO_STOP_EN - when defined, reaching 999.9 in RUNNING or LAP
//   forces PAUSED instead of letting the counter wrap.
//
// Ports:
//   clk_100MHz                 system clock
//   reset                      asynchronous active-high reset
//   btn_start/btn_lap/btn_clear raw pushbuttons, asynchronous, active-high
//   tenth_in..hundred_in       live BCD digits from the counter
//   run                        counter enable (RUNNING or LAP)
//   clr                        one-cycle counter clear pulse
//   lap_active                 high while the display is frozen
//   tenth_out..hundred_out     BCD digits to the 7-segment controller

module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_clear,
  input  logic [3:0] tenth_in,
  input  logic [3:0] ones_in,
  input  logic [3:0] tens_in,
  input  logic [3:0] hundred_in,
  output logic       run,
  output logic       clr,
  output logic       lap_active,
  output logic [3:0] tenth_out,
  output logic [3:0] ones_out,
  output logic [3:0] tens_out,
  output logic [3:0] hundred_out
);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, LAP} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit order for all button vectors: [0]=start, [1]=lap, [2]=clear.
  logic [2:0]       raw;
  logic [2:0]       sync1, sync2;
  logic [2:0]       deb, deb_prev;
  logic [2:0]       armed;
  logic [2:0]       press;
  logic [1:0]       vld;
  logic [CNT_W-1:0] cnt [3];

  assign raw = {btn_clear, btn_lap, btn_start};

  // vld marks when sync2 holds a real sample after reset. A button only becomes
  // armed once it has been seen released, so a button held through reset
  // cannot produce a press until it is let go and pressed again.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      deb      <= '0;
      deb_prev <= '0;
      armed    <= '0;
      press    <= '0;
      vld      <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      vld      <= {vld[0], 1'b1};
      deb_prev <= deb;
      armed    <= armed | ({3{vld[1]}} & ~sync2);
      press    <= deb & ~deb_prev & armed;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  logic p_start, p_lap, p_clear;
  assign p_start = press[0];
  assign p_lap   = press[1];
  assign p_clear = press[2];

  logic [15:0] live;
  assign live = {hundred_in, tens_in, ones_in, tenth_in};

  state_t state, state_next;
  logic   clr_next;
  logic   auto_stop;

`ifdef STOPWATCH_AUTO_STOP_EN
  assign auto_stop = ((state == RUNNING) || (state == LAP)) && (live == 16'h9999);
`else
  assign auto_stop = 1'b0;
`endif

  // Priority clear > start > lap; a press that is illegal in the current
  // state simply does not match its branch and falls through to the next.
  always_comb begin
    state_next = state;
    clr_next   = 1'b0;
    if (auto_stop) begin
      state_next = PAUSED;
    end else begin
      case (state)
        IDLE: begin
          if (p_clear)      clr_next   = 1'b1;
          else if (p_start) state_next = RUNNING;
        end
        RUNNING: begin
          if (p_start)      state_next = PAUSED;
          else if (p_lap)   state_next = LAP;
        end
        LAP: begin
          if (p_start)      state_next = PAUSED;
          else if (p_lap)   state_next = RUNNING;
        end
        PAUSED: begin
          if (p_clear) begin
            state_next = IDLE;
            clr_next   = 1'b1;
          end else if (p_start) begin
            state_next = RUNNING;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // The display registers double as the lap hold: they load the live digits on
  // every edge except while staying in LAP, so entering LAP captures *_in on
  // the same edge.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      run         <= 1'b0;
      clr         <= 1'b0;
      tenth_out   <= '0;
      ones_out    <= '0;
      tens_out    <= '0;
      hundred_out <= '0;
    end else begin
      state <= state_next;
      run   <= (state_next == RUNNING) || (state_next == LAP);
      clr   <= clr_next;
      if (!((state == LAP) && (state_next == LAP))) begin
        tenth_out   <= tenth_in;
        ones_out    <= ones_in;
        tens_out    <= tens_in;
        hundred_out <= hundred_in;
      end
    end
  end

  assign lap_active = (state == LAP);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4

module tb_stopwatch_ctrl;

  logic        clk;
  logic        reset;
  logic [2:0]  btns;
  logic [15:0] din;
  logic        run, clr, lap_active;
  logic [3:0]  tenth_out, ones_out, tens_out, hundred_out;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk_100MHz (clk),
    .reset      (reset),
    .btn_start  (btns[0]),
    .btn_lap    (btns[1]),
    .btn_clear  (btns[2]),
    .tenth_in   (din[3:0]),
    .ones_in    (din[7:4]),
    .tens_in    (din[11:8]),
    .hundred_in (din[15:12]),
    .run        (run),
    .clr        (clr),
    .lap_active (lap_active),
    .tenth_out  (tenth_out),
    .ones_out   (ones_out),
    .tens_out   (tens_out),
    .hundred_out(hundred_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [18:0] v;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [18:0] mk(input bit r, input bit c, input bit l, input logic [15:0] d);
    return {r, c, l, d};
  endfunction

  task automatic expect_at(input int c, input logic [18:0] v, input string nm);
    exp_t e;
    e.cyc  = c;
    e.v    = v;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents a sample, retire the expectations
  // scheduled for that cycle.
  logic [18:0] act;
  int          mi;
  always @(negedge clk) begin
    act = {run, clr, lap_active, hundred_out, tens_out, ones_out, tenth_out};
    mi  = 0;
    while (mi < exp_q.size()) begin
      if (exp_q[mi].cyc == cyc) begin
        n_checks++;
        if (act !== exp_q[mi].v) begin
          n_fail++;
          $display("FAIL %s cyc=%0d got run=%b clr=%b lap=%b digits=%h want run=%b clr=%b lap=%b digits=%h",
                   exp_q[mi].name, cyc, act[18], act[17], act[16], act[15:0],
                   exp_q[mi].v[18], exp_q[mi].v[17], exp_q[mi].v[16], exp_q[mi].v[15:0]);
        end
        exp_q.delete(mi);
      end else if (exp_q[mi].cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s missed at cyc=%0d (now %0d)", exp_q[mi].name, exp_q[mi].cyc, cyc);
        exp_q.delete(mi);
      end else begin
        mi++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [2:0] mask, input int hold);
    btns = mask;
    tick(hold);
    btns = 3'b000;
    tick(12);
  endtask

  int t0;

  initial begin
    reset = 1'b1;
    btns  = 3'b000;
    din   = 16'h0000;
    tick(2);
    expect_at(cyc, mk(0, 0, 0, 16'h0000), "reset_state");
    tick(1);
    reset = 1'b0;
    din   = 16'h0123;
    tick(4);

    // 3-cycle glitch on start must be ignored
    t0 = cyc;
    expect_at(t0 + 8,  mk(0, 0, 0, 16'h0123), "glitch_ignored");
    expect_at(t0 + 12, mk(0, 0, 0, 16'h0123), "glitch_ignored_late");
    press(3'b001, 3);

    // clean press: run rises exactly 8 cycles after the raw edge
    t0 = cyc;
    expect_at(t0 + 7, mk(0, 0, 0, 16'h0123), "start_latency_early");
    expect_at(t0 + 8, mk(1, 0, 0, 16'h0123), "start_latency");
    press(3'b001, 10);

    // second press pauses
    t0 = cyc;
    expect_at(t0 + 7, mk(1, 0, 0, 16'h0123), "pause_early");
    expect_at(t0 + 8, mk(0, 0, 0, 16'h0123), "pause");
    press(3'b001, 6);

    // resume with start held, then reset while still held
    t0 = cyc;
    expect_at(t0 + 8, mk(1, 0, 0, 16'h0123), "resume");
    btns = 3'b001;
    tick(10);
    reset = 1'b1;
    expect_at(cyc, mk(0, 0, 0, 16'h0000), "reset_async");
    tick(1);
    expect_at(cyc, mk(0, 0, 0, 16'h0000), "reset_hold");
    reset = 1'b0;
    expect_at(cyc + 6,  mk(0, 0, 0, 16'h0123), "no_pulse_after_reset");
    expect_at(cyc + 14, mk(0, 0, 0, 16'h0123), "no_pulse_after_reset_late");
    tick(16);
    btns = 3'b000;
    tick(12);

    t0 = cyc;
    expect_at(t0 + 8, mk(1, 0, 0, 16'h0123), "restart_after_release");
    press(3'b001, 6);

    // lap freezes the display while the live digits move on
    t0 = cyc;
    expect_at(t0 + 7, mk(1, 0, 0, 16'h0123), "lap_early");
    expect_at(t0 + 8, mk(1, 0, 1, 16'h0123), "lap_enter");
    press(3'b010, 6);
    din = 16'h0157;
    expect_at(cyc + 1, mk(1, 0, 1, 16'h0123), "lap_frozen");
    expect_at(cyc + 4, mk(1, 0, 1, 16'h0123), "lap_frozen_late");
    tick(5);

    t0 = cyc;
    expect_at(t0 + 7, mk(1, 0, 1, 16'h0123), "lap_exit_early");
    expect_at(t0 + 8, mk(1, 0, 0, 16'h0157), "lap_exit_live");
    press(3'b010, 6);
    din = 16'h0200;
    expect_at(cyc,     mk(1, 0, 0, 16'h0157), "live_prev");
    expect_at(cyc + 1, mk(1, 0, 0, 16'h0200), "live_track");
    tick(2);

    // start from LAP pauses and releases the hold
    t0 = cyc;
    expect_at(t0 + 8, mk(1, 0, 1, 16'h0200), "lap2_enter");
    press(3'b010, 6);
    din = 16'h0300;
    tick(2);
    t0 = cyc;
    expect_at(t0 + 7, mk(1, 0, 1, 16'h0200), "lap_start_early");
    expect_at(t0 + 8, mk(0, 0, 0, 16'h0300), "lap_start_pause");
    press(3'b001, 6);

    // clear and start together in PAUSED: clear wins
    t0 = cyc;
    expect_at(t0 + 7, mk(0, 0, 0, 16'h0300), "clr_early");
    expect_at(t0 + 8, mk(0, 1, 0, 16'h0300), "clr_pulse");
    expect_at(t0 + 9, mk(0, 0, 0, 16'h0300), "clr_one_cycle");
    press(3'b101, 6);

    t0 = cyc;
    expect_at(t0 + 8, mk(1, 0, 0, 16'h0300), "run_after_clear");
    press(3'b001, 6);

    // clear in RUNNING is ignored
    t0 = cyc;
    expect_at(t0 + 8, mk(1, 0, 0, 16'h0300), "clear_ignored");
    expect_at(t0 + 9, mk(1, 0, 0, 16'h0300), "clear_ignored_next");
    press(3'b100, 6);

    // terminal count
    din = 16'h9999;
`ifdef STOPWATCH_AUTO_STOP_EN
    expect_at(cyc + 1, mk(0, 0, 0, 16'h9999), "auto_stop");
    expect_at(cyc + 3, mk(0, 0, 0, 16'h9999), "auto_stop_hold");
`else
    expect_at(cyc + 1, mk(1, 0, 0, 16'h9999), "no_auto_stop");
    expect_at(cyc + 3, mk(1, 0, 0, 16'h9999), "no_auto_stop_hold");
`endif
    tick(4);

    for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick(1);
    while (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s never checked (cyc %0d)", exp_q[0].name, exp_q[0].cyc);
      exp_q.delete(0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
